// File: rtl/apb_multi_slave_mem.sv
// apb_multi_slave_mem: APB4 completer array of NO_OF_SLAVES word memories (ports: pclk/preset clock and async reset, psel..pprot/cfg_wait_states request, pready/prdata/pslverr response, fsm_state/err_count status)
module apb_multi_slave_mem #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NO_OF_SLAVES = 5,
  parameter int SLAVE_MEM_WORDS = 256,
  parameter int SLAVE_GAP_WORDS = 16,
  parameter int BIG_ENDIAN = 0,
  parameter logic [15:0] SECURE_MASK = 16'h0
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NO_OF_SLAVES-1:0]  psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [DATA_WIDTH/8-1:0]  pstrb,
  input  logic [2:0]               pprot,
  input  logic [3:0]               cfg_wait_states,
  output logic                     pready,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pslverr,
  output logic [2:0]               fsm_state,
  output logic [15:0]              err_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BSH = $clog2(BYTES);
  localparam int STRIDE = (SLAVE_MEM_WORDS + SLAVE_GAP_WORDS) * BYTES;
  localparam int DEPTH = NO_OF_SLAVES * SLAVE_MEM_WORDS;
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  function automatic int lane(input int i);
    return BIG_ENDIAN != 0 ? BYTES - 1 - i : i;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [MW-1:0] row_q, row_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [BYTES-1:0] st_q, st_d;
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [15:0] err_count_q, err_count_d;
  logic [3:0] sel_k;
  logic [ADDRESS_WIDTH-1:0] base, off, word;
  logic [MW-1:0] row;
  logic set_err, latch, done, commit;
  logic [DATA_WIDTH-1:0] wd_m, rd_m;
  logic [BYTES-1:0] st_m;
  logic unused_prot;

  assign unused_prot = ^{pprot[2], pprot[0]};

  // decode of the request presented at the setup edge; the lowest selected slave wins the index
  always_comb begin
    sel_k = '0;
    for (int i = NO_OF_SLAVES - 1; i >= 0; i--) if (psel[i]) sel_k = 4'(i);
    base = ADDRESS_WIDTH'(sel_k) * ADDRESS_WIDTH'(STRIDE);
    off = paddr - base;
    word = off >> BSH;
    row = MW'(sel_k) * MW'(SLAVE_MEM_WORDS) + MW'(word);
    set_err = |(psel & (psel - NO_OF_SLAVES'(1))) || paddr < base ||
              word >= ADDRESS_WIDTH'(SLAVE_MEM_WORDS) || (pprot[1] && SECURE_MASK[sel_k]) ||
              (!pwrite && |pstrb);
    wd_m = '0;
    st_m = '0;
    rd_m = '0;
    for (int i = 0; i < BYTES; i++) begin
      wd_m[8*lane(i) +: 8] = pwdata[8*i +: 8];
      st_m[lane(i)] = pstrb[i];
      rd_m[8*i +: 8] = mem_q[row_q][8*lane(i) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = row_q;
    wr_d = wr_q;
    err_d = err_q;
    wd_d = wd_q;
    st_d = st_q;
    err_count_d = err_count_q;
    pready_d = 1'b0;
    pslverr_d = 1'b0;
    prdata_d = '0;
    latch = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE: latch = |psel && !penable;
      S_SETUP: begin
        state_d = penable ? (cnt_q == 4'd0 ? S_ACCESS : S_WAIT) : S_IDLE;
        latch = !penable && |psel;
        done = penable && cnt_q == 4'd0;
      end
      S_WAIT: begin
        state_d = !(|psel) ? S_IDLE : cnt_q == 4'd1 ? S_ACCESS : S_WAIT;
        cnt_d = cnt_q - 4'd1;
        done = |psel && cnt_q == 4'd1;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        latch = |psel && !penable;
      end
      default: state_d = S_IDLE;
    endcase
    if (latch) begin
      state_d = S_SETUP;
      cnt_d = cfg_wait_states;
      row_d = row;
      wr_d = pwrite;
      err_d = set_err;
      wd_d = wd_m;
      st_d = st_m;
    end
    // the write commits on the same edge that raises pready, so any later read sees it
    if (done) begin
      pready_d = 1'b1;
      pslverr_d = err_q;
      prdata_d = wr_q || err_q ? '0 : rd_m;
      err_count_d = err_q && err_count_q != 16'hFFFF ? err_count_q + 16'd1 : err_count_q;
    end
  end

  assign commit = done && wr_q && !err_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      row_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      wd_q <= '0;
      st_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      wr_q <= wr_d;
      err_q <= err_d;
      wd_q <= wd_d;
      st_q <= st_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
      err_count_q <= err_count_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (commit) for (int i = 0; i < BYTES; i++) if (st_q[i]) mem_q[row_q][8*i +: 8] <= wd_q[8*i +: 8];
  end

  assign pready = pready_q;
  assign prdata = prdata_q;
  assign pslverr = pslverr_q;
  assign fsm_state = state_q;
  assign err_count = err_count_q;
endmodule
